// File: rtl/aes_apb_dma.sv
// APB master and word-stream adapter for the AES data registers.
// Moves 128-bit blocks as four 32-bit transfers on DMA request edges.
module aes_apb_dma #(
  parameter logic [3:0] DIN_ADDR  = 4'h2,
  parameter logic [3:0] DOUT_ADDR = 4'h3,
  parameter int         CNT_W     = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             en,
  input  logic             dma_req_wr,
  input  logic             dma_req_rd,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       PADDR,
  output logic [31:0]      PWDATA,
  output logic             PWRITE,
  output logic             PSEL,
  output logic             PENABLE,
  input  logic [31:0]      PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_blk_cnt,
  output logic [CNT_W-1:0] rd_blk_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_SETUP,
    WR_ACCESS,
    RD_SETUP,
    RD_ACCESS,
    RD_PUSH
  } state_t;

  state_t     state;
  logic [1:0] wcnt;
  logic       req_wr_q;
  logic       req_rd_q;
  logic       pend_wr;
  logic       pend_rd;
  logic       start_rd;
  logic       start_wr;
  logic       xfer_done;

  // Read wins so the core's output buffer drains before new input lands.
  assign start_rd  = (state == IDLE) & pend_rd & en;
  assign start_wr  = (state == IDLE) & ~pend_rd & pend_wr & en;
  assign xfer_done = PSEL & PENABLE & PREADY;
  assign busy      = (state != IDLE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      req_wr_q <= 1'b0;
      req_rd_q <= 1'b0;
      pend_wr  <= 1'b0;
      pend_rd  <= 1'b0;
    end else begin
      req_wr_q <= dma_req_wr;
      req_rd_q <= dma_req_rd;
      if (!en) begin
        pend_wr <= 1'b0;
        pend_rd <= 1'b0;
      end else begin
        pend_wr <= (pend_wr & ~start_wr) | (dma_req_wr & ~req_wr_q);
        pend_rd <= (pend_rd & ~start_rd) | (dma_req_rd & ~req_rd_q);
      end
    end
  end

  // A new error takes precedence over a simultaneous clear.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      err <= 1'b0;
    end else if (xfer_done && PSLVERR) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      wcnt       <= 2'd0;
      in_ready   <= 1'b0;
      out_data   <= 32'd0;
      out_valid  <= 1'b0;
      PADDR      <= 4'd0;
      PWDATA     <= 32'd0;
      PWRITE     <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      wr_blk_cnt <= '0;
      rd_blk_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_rd) begin
            state   <= RD_SETUP;
            wcnt    <= 2'd0;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= DOUT_ADDR;
          end else if (start_wr) begin
            state    <= WR_FETCH;
            wcnt     <= 2'd0;
            in_ready <= 1'b1;
          end
        end
        WR_FETCH: begin
          if (in_valid) begin
            PWDATA   <= in_data;
            in_ready <= 1'b0;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b1;
            PADDR    <= DIN_ADDR;
            state    <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          PENABLE <= 1'b1;
          state   <= WR_ACCESS;
        end
        WR_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (wcnt == 2'd3) begin
              wr_blk_cnt <= wr_blk_cnt + CNT_W'(1);
              state      <= IDLE;
            end else begin
              wcnt     <= wcnt + 2'd1;
              in_ready <= 1'b1;
              state    <= WR_FETCH;
            end
          end
        end
        RD_SETUP: begin
          PENABLE <= 1'b1;
          state   <= RD_ACCESS;
        end
        RD_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            out_data  <= PRDATA;
            out_valid <= 1'b1;
            state     <= RD_PUSH;
          end
        end
        RD_PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (wcnt == 2'd3) begin
              rd_blk_cnt <= rd_blk_cnt + CNT_W'(1);
              state      <= IDLE;
            end else begin
              wcnt    <= wcnt + 2'd1;
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PWRITE  <= 1'b0;
              PADDR   <= DOUT_ADDR;
              state   <= RD_SETUP;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_apb_dma.sv
// Directed bench for aes_apb_dma: APB slave model plus stream source/sink.
// Counters are built narrow so block-count wrap is reachable.
module tb_aes_apb_dma;

  localparam int CW = 2;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          en = 1'b1;
  logic          dma_req_wr = 1'b0;
  logic          dma_req_rd = 1'b0;
  logic [31:0]   in_data;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic          busy;
  logic          err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] wr_blk_cnt;
  logic [CW-1:0] rd_blk_cnt;

  aes_apb_dma #(.DIN_ADDR(4'h2), .DOUT_ADDR(4'h3), .CNT_W(CW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .en(en),
    .dma_req_wr(dma_req_wr), .dma_req_rd(dma_req_rd),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .err(err), .err_clr(err_clr),
    .wr_blk_cnt(wr_blk_cnt), .rd_blk_cnt(rd_blk_cnt)
  );

  always #5 PCLK = ~PCLK;

  logic [31:0] wtab [4] = '{32'h00112233, 32'h44556677,
                            32'h8899AABB, 32'hCCDDEEFF};
  logic [3:0]  log_addr [$];
  logic        log_wr [$];
  logic [31:0] log_data [$];
  logic [31:0] out_q [$];
  int wr_xfers = 0;
  int rd_xfers = 0;
  int in_idx = 0;
  int st_cnt = 0;
  int pen_cnt = 0;
  int setup_cnt = 0;
  int ws_target = 0;
  int st_base = 0;
  logic ws_mode = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  assign in_data = wtab[in_idx[1:0]];
  assign PRDATA  = 32'hA0 + 32'(rd_xfers[1:0]);
  assign PREADY  = !(ws_mode && PWRITE && wr_xfers == ws_target
                     && (st_cnt - st_base) < 3);
  assign PSLVERR = ws_mode && PWRITE && wr_xfers == ws_target;

  always @(posedge PCLK) begin
    if (PSEL && !PENABLE) setup_cnt <= setup_cnt + 1;
    if (PSEL && PENABLE && !PREADY) st_cnt <= st_cnt + 1;
    if (ws_mode && PENABLE && PWRITE && wr_xfers == ws_target)
      pen_cnt <= pen_cnt + 1;
    if (PSEL && PENABLE && PREADY) begin
      log_addr.push_back(PADDR);
      log_wr.push_back(PWRITE);
      log_data.push_back(PWRITE ? PWDATA : PRDATA);
      if (PWRITE) wr_xfers <= wr_xfers + 1;
      else rd_xfers <= rd_xfers + 1;
    end
    if (in_valid && in_ready) in_idx <= in_idx + 1;
    if (out_valid && out_ready) out_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < lim) begin
      tick(1);
      k++;
    end
    chk1(tag, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int obase;
    int k;

    tick(3);
    chk1("rst_psel", PSEL, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_wr_cnt", 32'(wr_blk_cnt), 0);
    chk("rst_rd_cnt", 32'(rd_blk_cnt), 0);
    chk("rst_paddr", 32'(PADDR), 0);
    chk("rst_out_data", out_data, 0);
    PRESET = 1'b0;
    tick(2);

    // write block, 12 cycles from IDLE exit
    in_valid = 1'b1;
    out_ready = 1'b1;
    base = log_addr.size();
    k = setup_cnt;
    dma_req_wr = 1'b1;
    tick(1);
    chk1("wr_lat_edge", busy, 1'b0);
    dma_req_wr = 1'b0;
    tick(1);
    chk1("wr_lat_start", busy, 1'b1);
    tick(11);
    chk1("wr_cyc11", busy, 1'b1);
    tick(1);
    chk1("wr_cyc12", busy, 1'b0);
    chk("wr_nxfer", log_addr.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_addr%0d", i), 32'(log_addr[base+i]), 32'h2);
      chk1($sformatf("wr_dir%0d", i), log_wr[base+i], 1'b1);
      chk($sformatf("wr_data%0d", i), log_data[base+i], wtab[i]);
    end
    chk("wr_setups", setup_cnt - k, 4);
    chk("wr_blk1", 32'(wr_blk_cnt), 1);

    // read block with sink stall on word 1
    base = log_addr.size();
    obase = out_q.size();
    dma_req_rd = 1'b1;
    tick(1);
    dma_req_rd = 1'b0;
    k = 0;
    while (out_q.size() - obase < 1 && k < 40) begin
      tick(1);
      k++;
    end
    chk("rd_w0_seen", out_q.size() - obase, 1);
    out_ready = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("rd_stall_v%0d", i), out_valid, 1'b1);
      chk($sformatf("rd_stall_d%0d", i), out_data, 32'hA1);
      chk1($sformatf("rd_stall_psel%0d", i), PSEL, 1'b0);
      tick(1);
    end
    out_ready = 1'b1;
    wait_idle("rd_done", 40);
    chk("rd_nout", out_q.size() - obase, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_word%0d", i), out_q[obase+i], 32'hA0 + 32'(i));
      chk($sformatf("rd_addr%0d", i), 32'(log_addr[base+i]), 32'h3);
      chk1($sformatf("rd_dir%0d", i), log_wr[base+i], 1'b0);
    end
    chk("rd_blk1", 32'(rd_blk_cnt), 1);

    // simultaneous requests: read block first, then write block
    base = log_addr.size();
    dma_req_wr = 1'b1;
    dma_req_rd = 1'b1;
    tick(1);
    dma_req_wr = 1'b0;
    dma_req_rd = 1'b0;
    k = 0;
    while (!(wr_blk_cnt == 2'd2 && busy == 1'b0) && k < 80) begin
      tick(1);
      k++;
    end
    chk("both_wr_cnt", 32'(wr_blk_cnt), 2);
    chk("both_rd_cnt", 32'(rd_blk_cnt), 2);
    chk("both_nxfer", log_addr.size() - base, 8);
    for (int i = 0; i < 8; i++)
      chk1($sformatf("both_order%0d", i), log_wr[base+i], i >= 4);

    // wait states and slave error on write word 2
    ws_target = wr_xfers + 2;
    st_base = st_cnt;
    ws_mode = 1'b1;
    dma_req_wr = 1'b1;
    tick(1);
    dma_req_wr = 1'b0;
    tick(1);
    chk1("ws_start", busy, 1'b1);
    tick(14);
    chk1("ws_cyc14", busy, 1'b1);
    tick(1);
    chk1("ws_cyc15", busy, 1'b0);
    chk("ws_penable", pen_cnt, 4);
    chk1("ws_err", err, 1'b1);
    chk("ws_blk", 32'(wr_blk_cnt), 3);
    ws_mode = 1'b0;
    tick(3);
    chk1("err_sticky", err, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk1("err_cleared", err, 1'b0);

    // enable gating drops the pending request
    en = 1'b0;
    base = log_addr.size();
    dma_req_wr = 1'b1;
    tick(1);
    dma_req_wr = 1'b0;
    tick(5);
    chk1("en0_busy", busy, 1'b0);
    chk("en0_noxfer", log_addr.size() - base, 0);
    en = 1'b1;
    tick(5);
    chk1("en1_busy", busy, 1'b0);
    chk("en1_noxfer", log_addr.size() - base, 0);

    // fourth write block wraps the 2-bit counter
    dma_req_wr = 1'b1;
    tick(1);
    dma_req_wr = 1'b0;
    tick(1);
    chk1("wrap_start", busy, 1'b1);
    wait_idle("wrap_done", 40);
    chk("wrap_cnt", 32'(wr_blk_cnt), 0);

    // en dropped mid-read still completes the block
    obase = out_q.size();
    dma_req_rd = 1'b1;
    tick(1);
    dma_req_rd = 1'b0;
    tick(2);
    chk1("rden_access", PENABLE, 1'b1);
    en = 1'b0;
    wait_idle("rden_done", 40);
    chk("rden_cnt", 32'(rd_blk_cnt), 3);
    chk("rden_nout", out_q.size() - obase, 4);
    en = 1'b1;
    tick(2);

    // reset during write word 2 access
    base = wr_xfers;
    dma_req_wr = 1'b1;
    tick(1);
    dma_req_wr = 1'b0;
    k = 0;
    while (!(PENABLE === 1'b1 && PWRITE === 1'b1 && wr_xfers == base + 2)
           && k < 40) begin
      tick(1);
      k++;
    end
    chk1("rst_mid_reached", PENABLE, 1'b1);
    PRESET = 1'b1;
    #1;
    chk1("rstm_psel", PSEL, 1'b0);
    chk1("rstm_penable", PENABLE, 1'b0);
    chk1("rstm_in_ready", in_ready, 1'b0);
    chk1("rstm_out_valid", out_valid, 1'b0);
    chk1("rstm_busy", busy, 1'b0);
    chk("rstm_wr_cnt", 32'(wr_blk_cnt), 0);
    chk("rstm_rd_cnt", 32'(rd_blk_cnt), 0);
    tick(2);
    PRESET = 1'b0;
    tick(1);
    base = wr_xfers;
    dma_req_wr = 1'b1;
    tick(1);
    dma_req_wr = 1'b0;
    tick(1);
    chk1("post_start", busy, 1'b1);
    wait_idle("post_done", 40);
    chk("post_blk", 32'(wr_blk_cnt), 1);
    chk("post_nxfer", wr_xfers - base, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
